// File: rtl/message_loader.sv
// -----------------------------------------------------------------------------
// message_loader
//
// Collects ASCII characters from a valid/ready stream into a shadow buffer.
// A carriage return (or filling the buffer) commits the message. The shadow
// buffer is then copied, one index per cycle, into an active buffer that a
// scroller reads through rd_idx/rd_char. msg_update pulses once when the new
// message is fully active.
//
// Optional feature macro:
//   MSG_LOADER_UPPERCASE_EN - fold a-z to A-Z before storing in shadow.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   char_in     incoming ASCII character
//   char_valid  char_in is valid this cycle
//   char_ready  loader accepts char_in this cycle (high only while filling)
//   rd_idx      read index from the scroller
//   rd_char     registered active[rd_idx], space when rd_idx >= MSG_LEN
//   msg_len     length of the committed (active) message
//   msg_update  one-cycle pulse when a new message becomes active
// -----------------------------------------------------------------------------
module message_loader #(
  parameter int MSG_LEN    = 11,
  parameter int CHAR_WIDTH = 8,
  localparam int IDX_W     = $clog2(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHAR_WIDTH-1:0] char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [CHAR_WIDTH-1:0] rd_char,
  output logic [IDX_W:0]        msg_len,
  output logic                  msg_update
);

  localparam logic [CHAR_WIDTH-1:0] SPACE = CHAR_WIDTH'(32'h20);
  localparam logic [CHAR_WIDTH-1:0] BS    = CHAR_WIDTH'(32'h08);
  localparam logic [CHAR_WIDTH-1:0] CR    = CHAR_WIDTH'(32'h0D);
  localparam logic [CHAR_WIDTH-1:0] DEL   = CHAR_WIDTH'(32'h7F);

  localparam logic [IDX_W:0]   LEN_FULL = (IDX_W+1)'(MSG_LEN);
  localparam logic [IDX_W:0]   LAST_PTR = (IDX_W+1)'(MSG_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  typedef enum logic {FILL, COPY} state_t;

  state_t state, state_nxt;

  logic [CHAR_WIDTH-1:0] shadow [MSG_LEN];
  logic [CHAR_WIDTH-1:0] active [MSG_LEN];

  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   len;
  logic [IDX_W-1:0] copy_idx;

  // ---------------------------------------------------------------------------
  // Character decode
  // ---------------------------------------------------------------------------
  function automatic logic [CHAR_WIDTH-1:0] to_stored(input logic [CHAR_WIDTH-1:0] c);
`ifdef MSG_LOADER_UPPERCASE_EN
    if (c >= CHAR_WIDTH'(32'h61) && c <= CHAR_WIDTH'(32'h7A))
      return c - CHAR_WIDTH'(32'h20);
    else
      return c;
`else
    return c;
`endif
  endfunction

  logic xfer;
  logic is_print;
  logic is_bs;
  logic is_cr;
  logic ptr_zero;
  logic commit;
  logic copy_last;

  assign xfer      = char_valid && char_ready;
  assign is_print  = (char_in >= SPACE) && (char_in != DEL);
  assign is_bs     = (char_in == BS);
  assign is_cr     = (char_in == CR);
  assign ptr_zero  = (wr_ptr == '0);
  // A CR on a non-empty buffer commits; so does the write that fills it.
  assign commit    = xfer && ((is_cr && !ptr_zero) || (is_print && wr_ptr == LAST_PTR));
  assign copy_last = (copy_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      FILL: if (commit)    state_nxt = COPY;
      COPY: if (copy_last) state_nxt = FILL;
      default:             state_nxt = FILL;
    endcase
  end

  always_comb begin
    char_ready = (state == FILL);
  end

  // ---------------------------------------------------------------------------
  // Shadow buffer: written while filling, contents undefined after reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == FILL && xfer && is_print)
      shadow[wr_ptr[IDX_W-1:0]] <= to_stored(char_in);
  end

  // ---------------------------------------------------------------------------
  // Write pointer, latched length, copy index, committed length, update pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      wr_ptr     <= '0;
      len        <= '0;
      copy_idx   <= '0;
      msg_len    <= '0;
      msg_update <= 1'b0;
    end else begin
      msg_update <= 1'b0;
      case (state)
        FILL: begin
          copy_idx <= '0;
          if (xfer) begin
            if (is_print) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_ptr == LAST_PTR) len <= LEN_FULL;
            end else if (is_bs && !ptr_zero) begin
              wr_ptr <= wr_ptr - 1'b1;
            end else if (is_cr && !ptr_zero) begin
              len <= wr_ptr;
            end
          end
        end
        COPY: begin
          if (copy_last) begin
            copy_idx   <= '0;
            wr_ptr     <= '0;
            msg_len    <= len;
            msg_update <= 1'b1;
          end else begin
            copy_idx <= copy_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Active buffer: reset to spaces so an aborted copy never shows stale text
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this memory is reset on purpose (it must read as spaces); shadow is deliberately left unreset.
      for (int i = 0; i < MSG_LEN; i++) active[i] <= SPACE;
    end else if (state == COPY) begin
      active[copy_idx] <= ({1'b0, copy_idx} < len) ? shadow[copy_idx] : SPACE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          rd_char <= SPACE;
    else if ({1'b0, rd_idx} < LEN_FULL)  rd_char <= active[rd_idx];
    else                                 rd_char <= SPACE;
  end

endmodule

// File: doc/message_loader.md
MESSAGE_LOADER -- requirements
Module: message_loader

Interface
REQ-001 SHALL have parameter MSG_LEN, default 11, meaning character capacity of the message buffers.
REQ-002 SHALL have parameter CHAR_WIDTH, default 8, meaning bits per ASCII character.
REQ-003 SHALL have localparam IDX_W = $clog2(MSG_LEN), meaning the index and length width.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port char_in  input  CHAR_WIDTH  incoming ASCII character.
REQ-007 SHALL have port char_valid  input  1  char_in is valid this cycle.
REQ-008 SHALL have port char_ready  output  1  loader accepts char_in this cycle.
REQ-009 SHALL have port rd_idx  input  IDX_W  read index from the scroller.
REQ-010 SHALL have port rd_char  output  CHAR_WIDTH  registered active-buffer character at rd_idx.
REQ-011 SHALL have port msg_len  output  IDX_W+1  committed message length.
REQ-012 SHALL have port msg_update  output  1  one-cycle pulse when a new message becomes active.

Function
REQ-013 SHALL transfer a character only on a cycle where char_valid and char_ready are both 1.
REQ-014 SHALL hold two buffers of MSG_LEN characters: shadow (written) and active (read).
REQ-015 SHALL implement the states FILL and COPY.
REQ-016 SHALL drive char_ready = 1 only in FILL.
REQ-017 In FILL, for a transferred printable character, SHALL write it to shadow[wr_ptr] and increment wr_ptr.
REQ-018 For a transferred 0x08 (backspace) with wr_ptr > 0, SHALL decrement wr_ptr; with wr_ptr = 0, SHALL consume it with no effect.
REQ-019 For a transferred 0x0D (CR) with wr_ptr > 0, SHALL latch len = wr_ptr and go to COPY; with wr_ptr = 0, SHALL consume it with no effect.
REQ-020 SHALL treat the write that makes wr_ptr reach MSG_LEN as an implicit commit: latch len = MSG_LEN and go to COPY the next cycle.
REQ-021 SHALL discard other control characters (< 0x20, or 0x7F) while still consuming them.
REQ-022 In COPY, SHALL copy one index per cycle from 0 to MSG_LEN-1, taking MSG_LEN cycles.
REQ-023 During COPY, SHALL write active[i] = shadow[i] for i < len, and 0x20 (space) otherwise.
REQ-024 On the final COPY cycle, SHALL update msg_len = len and clear wr_ptr to 0.
REQ-025 SHALL assert msg_update for exactly one cycle, on the cycle after the final COPY write, then return to FILL.
REQ-026 SHALL update rd_char to active[rd_idx] one cycle after rd_idx is applied.
REQ-027 SHALL drive rd_char = 0x20 when rd_idx >= MSG_LEN.
REQ-028 During COPY, rd_char may return a mix of old and new characters; msg_len SHALL remain at the old value until the final COPY cycle.

Reset
REQ-029 On rst_n low, SHALL immediately enter FILL with wr_ptr = 0.
REQ-030 On rst_n low, SHALL set all active entries to 0x20, and set msg_len = 0, msg_update = 0 and rd_char = 0x20.
REQ-031 SHALL leave shadow contents unspecified after reset.
REQ-032 A reset during COPY SHALL abort the copy; the active buffer SHALL read as all spaces afterwards.

Configuration
REQ-033 When MSG_LOADER_UPPERCASE_EN is defined, SHALL convert accepted characters 0x61-0x7A (a-z) to 0x41-0x5A before storing them in shadow.
REQ-034 When MSG_LOADER_UPPERCASE_EN is undefined, SHALL store characters unmodified.

Verification
REQ-035 Bench SHALL cover: reset, then read rd_idx 0..10 -> rd_char = 0x20 each, msg_len = 0, char_ready = 1.
REQ-036 Bench SHALL cover: send "HELLO" then 0x0D -> char_ready low 11 cycles, msg_update pulse once, msg_len = 5, rd_idx 0..4 = "HELLO", rd_idx 5..10 = 0x20.
REQ-037 Bench SHALL cover: send 11 chars "ABCDEFGHIJK" with no CR -> auto-commit, msg_len = 11, rd_idx 10 = 'K'.
REQ-038 Bench SHALL cover: send "AB", 0x08, "C", 0x0D -> msg_len = 2, contents "AC"; also 0x0D alone -> no msg_update.
REQ-039 Bench SHALL cover: assert rst_n low 3 cycles into COPY -> all reads 0x20, msg_len = 0, no msg_update.
REQ-040 Bench SHALL cover: send "hi", 0x0D with MSG_LOADER_UPPERCASE_EN defined -> "HI"; undefined -> "hi".
